sync_edge_timestamp_fifo: RTL

Downstream consumer of the debounced, synchronized level produced by the input synchronizer stage. It detects qualifying edges on that level and stamps each one with a free-running cycle counter. Each event is queued in a small FIFO and presented on a first-word-fall-through valid/ready port for the register/readout logic. It also keeps a sticky overflow flag and a saturating count of dropped events.

---
 rtl/sync_edge_timestamp_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sync_edge_timestamp_fifo.sv
// -----------------------------------------------------------------------------
// sync_edge_timestamp_fifo
//
// Detects qualifying edges on an already-synchronized, debounced level and
// stamps each one with a free-running cycle counter. Events are queued in a
// small circular FIFO and presented first-word-fall-through on a valid/ready
// port. A sticky overflow flag and a saturating drop counter record events
// that arrived while the FIFO was full and not being drained.
//
// Ports:
//   clk            single clock, all logic on posedge
//   resn           asynchronous active-low reset
//   sync_in        synchronized level in the clk domain
//   enable         1 = capture qualifying edges, 0 = ignore edges (FIFO drains)
//   edge_sel       bit0 = capture rising edges, bit1 = capture falling edges
//   ts_clear       synchronous clear of the timestamp counter
//   evt_valid      FIFO head valid
//   evt_ready      consumer accepts head
//   evt_ts         head timestamp
//   evt_rising     head edge type, 1 = rising, 0 = falling
//   fifo_count     number of stored entries
//   overflow       sticky, an event was dropped
//   overflow_clear clears overflow and drop_count
//   drop_count     dropped events, saturates at 255
// -----------------------------------------------------------------------------
module sync_edge_timestamp_fifo #(
  parameter int   TS_WIDTH   = 16,
  parameter int   FIFO_DEPTH = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                          clk,
  input  logic                          resn,
  input  logic                          sync_in,
  input  logic                          enable,
  input  logic [1:0]                    edge_sel,
  input  logic                          ts_clear,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic                          evt_rising,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clear,
  output logic [7:0]                    drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                prev_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] mem_ts   [FIFO_DEPTH];
  logic                mem_rise [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count_q;
  logic                overflow_q;
  logic [7:0]          drop_q;

  logic rise;
  logic fall;
  logic evt_qual;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Edge detection against the previous-cycle level
  assign rise     = sync_in & ~prev_q;
  assign fall     = ~sync_in & prev_q;
  assign evt_qual = enable & ((rise & edge_sel[0]) | (fall & edge_sel[1]));

  assign full = (count_q == DEPTH_C);
  assign pop  = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push = evt_qual & (~full | pop);
  assign drop = evt_qual & full & ~pop;

  // Outputs decoded from registers only; head follows rd_ptr with no bubble
  assign evt_valid  = (count_q != '0);
  assign evt_ts     = mem_ts[rd_ptr];
  assign evt_rising = mem_rise[rd_ptr];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      prev_q <= INIT_LEVEL;
      ts_q   <= '0;
    end else begin
      prev_q <= sync_in;
      if (ts_clear) begin
        ts_q <= '0;
      end else begin
        ts_q <= ts_q + TS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ts[i]   <= '0;
        mem_rise[i] <= 1'b0;
      end
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_ts[wr_ptr]   <= ts_q;
        mem_rise[wr_ptr] <= rise;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // A drop in the same cycle as overflow_clear wins and counts as the first
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (overflow_clear) begin
        drop_q <= 8'd1;
      end else if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end else if (overflow_clear) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

endmodule
